// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: each requester may hold the grant for up to
// weight[j] consecutive accepted cycles before the grant rotates to the next requester.
module weighted_rr_arbiter #(
   parameter int REQ_WIDTH    = 4,
   parameter int WEIGHT_WIDTH = 4,
   localparam int IDX_WIDTH   = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              ready_in,
   input  logic [REQ_WIDTH-1:0]              req,
   input  logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] weight,
   output logic [REQ_WIDTH-1:0]              grant,
   output logic [IDX_WIDTH-1:0]              grant_idx,
   output logic                              grant_valid
);

   logic [IDX_WIDTH-1:0]    ptr;
   logic [WEIGHT_WIDTH-1:0] credit;

   logic [WEIGHT_WIDTH-1:0] weight_arr [REQ_WIDTH];
   logic                    search_hit;
   logic [IDX_WIDTH-1:0]    search_idx;
   logic [IDX_WIDTH-1:0]    cand;
   logic [WEIGHT_WIDTH-1:0] load_credit;
   logic                    continue_burst;

   for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_unpack
      assign weight_arr[g] = weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
   end

   // Circular search starting just after ptr, so the last holder is examined last.
   // NOTE: every signal written here gets a default first; otherwise a path that skips it infers a latch.
   always_comb begin
      search_hit = 1'b0;
      search_idx = ptr;
      cand       = ptr;
      for (int k = 1; k <= REQ_WIDTH; k++) begin
         cand = IDX_WIDTH'((int'(ptr) + k) % REQ_WIDTH);
         if (!search_hit && req[cand]) begin
            search_hit = 1'b1;
            search_idx = cand;
         end
      end
   end

   // A zero weight still buys one grant, so credit is never zero while a grant is live.
   always_comb begin
      load_credit = weight_arr[search_idx];
      if (weight_arr[search_idx] == '0) begin
         load_credit = WEIGHT_WIDTH'(1);
      end
   end

   assign continue_burst = grant_valid && req[grant_idx] && (credit > WEIGHT_WIDTH'(1));

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant       <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         credit      <= '0;
         ptr         <= IDX_WIDTH'(REQ_WIDTH - 1);
      end else if (ready_in) begin
         if (continue_burst) begin
            credit <= credit - WEIGHT_WIDTH'(1);
         end else if (search_hit) begin
            grant       <= REQ_WIDTH'(1) << search_idx;
            grant_idx   <= search_idx;
            grant_valid <= 1'b1;
            ptr         <= search_idx;
            credit      <= load_credit;
         end else begin
            // Idle keeps ptr and grant_idx so fairness carries across the gap.
            grant       <= '0;
            grant_valid <= 1'b0;
            credit      <= '0;
         end
      end
   end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: directed scenarios followed by random traffic,
// all compared against an integer-level reference model of the arbitration rules.
module tb_weighted_rr_arbiter;

   localparam int N  = 4;
   localparam int WW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ready_in;
   logic [N-1:0]  req;
   logic [N*WW-1:0] weight;
   logic [N-1:0]  grant;
   logic [1:0]    grant_idx;
   logic          grant_valid;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int m_ptr;
   int m_idx;
   int m_credit;
   bit m_valid;

   weighted_rr_arbiter #(.REQ_WIDTH(N), .WEIGHT_WIDTH(WW)) dut (
      .clk        (clk),
      .rst        (rst),
      .ready_in   (ready_in),
      .req        (req),
      .weight     (weight),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .grant_valid(grant_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int w;
      bit hit;
      if (rst) begin
         m_valid = 0; m_idx = 0; m_credit = 0; m_ptr = N - 1;
      end else if (ready_in) begin
         if (m_valid && req[m_idx] && m_credit > 1) begin
            m_credit--;
         end else begin
            hit = 0;
            for (int k = 1; k <= N; k++) begin
               int j = (m_ptr + k) % N;
               if (!hit && req[j]) begin
                  hit = 1;
                  w = int'(weight[j*WW +: WW]);
                  m_valid = 1; m_idx = j; m_ptr = j;
                  m_credit = (w == 0) ? 1 : w;
               end
            end
            if (!hit) begin
               m_valid = 0; m_credit = 0;
            end
         end
      end
   endtask

   // One clock: drive inputs on the falling edge, step the model at the rising
   // edge, compare just after it. use_exp adds a literal check of grant.
   task automatic step(input string tag, input logic r, input logic rdy, input logic [N-1:0] rq,
                       input bit use_exp, input logic [N-1:0] exp_g);
      logic [N-1:0] m_grant;
      @(negedge clk);
      rst = r; ready_in = rdy; req = rq;
      @(posedge clk);
      model_edge();
      #1;
      m_grant = m_valid ? N'(1) << m_idx : '0;
      check({tag, ".grant"}, 32'(grant), 32'(m_grant));
      check({tag, ".grant_valid"}, 32'(grant_valid), 32'(m_valid));
      check({tag, ".grant_idx"}, 32'(grant_idx), 32'(m_idx));
      if (use_exp) check({tag, ".grant_lit"}, 32'(grant), 32'(exp_g));
   endtask

   task automatic set_w(input int j, input int v);
      weight[j*WW +: WW] = WW'(v);
   endtask

   initial begin
      rst = 1'b1; ready_in = 1'b0; req = '0; weight = '0;
      m_ptr = N - 1; m_idx = 0; m_credit = 0; m_valid = 0;
      for (int j = 0; j < N; j++) set_w(j, 1);

      // 1: reset, then first grant
      step("t1_rst0", 1, 1, 4'b1111, 1, 4'b0000);
      step("t1_rst1", 1, 1, 4'b1111, 1, 4'b0000);
      step("t1_first", 0, 1, 4'b0001, 1, 4'b0001);

      // 2: plain round robin with unit weights
      step("t2_rst", 1, 1, 4'b0000, 1, 4'b0000);
      step("t2_g0", 0, 1, 4'b0111, 1, 4'b0001);
      step("t2_g1", 0, 1, 4'b0111, 1, 4'b0010);
      step("t2_g2", 0, 1, 4'b0111, 1, 4'b0100);
      step("t2_g3", 0, 1, 4'b0111, 1, 4'b0001);
      step("t2_g4", 0, 1, 4'b0111, 1, 4'b0010);

      // 3: weight0=3 burst
      set_w(0, 3);
      step("t3_rst", 1, 1, 4'b0000, 1, 4'b0000);
      step("t3_g0", 0, 1, 4'b0011, 1, 4'b0001);
      step("t3_g1", 0, 1, 4'b0011, 1, 4'b0001);
      step("t3_g2", 0, 1, 4'b0011, 1, 4'b0001);
      step("t3_g3", 0, 1, 4'b0011, 1, 4'b0010);
      step("t3_g4", 0, 1, 4'b0011, 1, 4'b0001);
      step("t3_g5", 0, 1, 4'b0011, 1, 4'b0001);
      step("t3_g6", 0, 1, 4'b0011, 1, 4'b0001);
      step("t3_g7", 0, 1, 4'b0011, 1, 4'b0010);

      // 4: stall mid-burst
      step("t4_rst", 1, 1, 4'b0000, 1, 4'b0000);
      step("t4_g0", 0, 1, 4'b0011, 1, 4'b0001);
      step("t4_g1", 0, 1, 4'b0011, 1, 4'b0001);
      step("t4_st0", 0, 0, 4'b0011, 1, 4'b0001);
      step("t4_st1", 0, 0, 4'b0110, 1, 4'b0001);
      step("t4_g2", 0, 1, 4'b0011, 1, 4'b0001);
      step("t4_g3", 0, 1, 4'b0011, 1, 4'b0010);

      // 5: holder drops req mid-burst
      step("t5_rst", 1, 1, 4'b0000, 1, 4'b0000);
      step("t5_g0", 0, 1, 4'b0011, 1, 4'b0001);
      step("t5_g1", 0, 1, 4'b0010, 1, 4'b0010);

      // 6: zero weight, idle, fairness across idle, reset mid-burst
      set_w(0, 1); set_w(2, 0); set_w(3, 3);
      step("t6_rst", 1, 1, 4'b0000, 1, 4'b0000);
      step("t6_w0a", 0, 1, 4'b0100, 1, 4'b0100);
      step("t6_w0b", 0, 1, 4'b0100, 1, 4'b0100);
      step("t6_w0c", 0, 1, 4'b0100, 1, 4'b0100);
      step("t6_idle", 0, 1, 4'b0000, 1, 4'b0000);
      step("t6_fair", 0, 1, 4'b1111, 1, 4'b1000);
      step("t6_burst", 0, 1, 4'b1111, 1, 4'b1000);
      step("t6_rstmid", 1, 1, 4'b1111, 1, 4'b0000);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            for (int j = 0; j < N; j++) set_w(j, int'($urandom_range(0, 15)));
         end
         step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              N'($urandom_range(0, 15)), 0, '0);
         vectors++;
         assert (grant === '0 || $onehot(grant)) else begin
            miscompares++;
            $error("FAIL rand.onehot: observed %0h expected one-hot or zero", grant);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
